// File: rtl/inst_encoder.sv
// ============================================================================
// inst_encoder
// ----------------------------------------------------------------------------
// Packs a format tag, register fields, funct fields and a 32-bit immediate
// into RV32I instruction words. It is the inverse of the decode-stage
// immediate generator. Every immediate is range-checked, and the LI
// pseudo-instruction is expanded into ADDI, LUI, or LUI followed by ADDI.
//
// Ports
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   req_valid   in   1  request present
//   req_ready   out  1  request accepted when req_valid & req_ready
//   req_fmt     in   3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 LI, 7 reserved
//   req_opcode  in   7  opcode (ignored for LI)
//   req_funct3  in   3  funct3 (ignored for U, J, LI)
//   req_funct7  in   7  funct7 (R only)
//   req_rd      in   5  destination register
//   req_rs1     in   5  source register 1
//   req_rs2     in   5  source register 2
//   req_imm     in  32  immediate as a full signed byte value
//   inst_valid  out  1  output word valid
//   inst_ready  in   1  downstream accepts the word on inst_valid & inst_ready
//   inst        out 32  encoded instruction word
//   inst_last   out  1  last word of the current request
//   inst_err    out  1  immediate out of range / misaligned, or reserved fmt
// ============================================================================
module inst_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_fmt,
    input  logic [6:0]  req_opcode,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic        inst_last,
    output logic        inst_err
);

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_LI   = 3'd6,
        FMT_RSVD = 3'd7
    } fmt_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OUT_LAST  = 2'd1,
        OUT_FIRST = 2'd2
    } state_t;

    localparam logic [6:0] OP_OP_IMM = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [2:0] F3_ADDI   = 3'd0;
    localparam logic [4:0] REG_X0    = 5'd0;

    state_t      state;
    logic [31:0] pend;
    // Held low until the first clock after reset release, so that no request
    // is ever acknowledged while the block is (or has just been) in reset.
    logic        accept_en;

    fmt_t        fmt;
    logic        accept;

    // Range predicates: the value is representable in N signed bits when all
    // bits from N-1 upward are copies of the sign.
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic [19:0] li_hi;

    // Encoding of the request currently on the input port.
    logic [31:0] enc_word;
    logic        enc_err;
    logic        enc_two;
    logic [31:0] enc_pend;

    assign fmt    = fmt_t'(req_fmt);
    assign fits12 = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    assign fits13 = (&req_imm[31:12]) | ~(|req_imm[31:12]);
    assign fits21 = (&req_imm[31:20]) | ~(|req_imm[31:20]);

    // The ADDI that follows the LUI sign-extends its 12-bit field, so the
    // upper part is rounded up whenever bit 11 is set.
    assign li_hi = req_imm[31:12] + {19'd0, req_imm[11]};

    assign req_ready = accept_en & (~inst_valid | (inst_ready & inst_last));
    assign accept    = req_valid & req_ready;

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        enc_two  = 1'b0;
        enc_pend = '0;
        case (fmt)
            FMT_R: begin
                enc_word = {req_funct7, req_rs2, req_rs1, req_funct3,
                            req_rd, req_opcode};
            end
            FMT_I: begin
                enc_word = {req_imm[11:0], req_rs1, req_funct3,
                            req_rd, req_opcode};
                enc_err  = ~fits12;
            end
            FMT_S: begin
                enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                            req_imm[4:0], req_opcode};
                enc_err  = ~fits12;
            end
            FMT_B: begin
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1,
                            req_funct3, req_imm[4:1], req_imm[11], req_opcode};
                enc_err  = ~fits13 | req_imm[0];
            end
            FMT_U: begin
                enc_word = {req_imm[31:12], req_rd, req_opcode};
                enc_err  = |req_imm[11:0];
            end
            FMT_J: begin
                enc_word = {req_imm[20], req_imm[10:1], req_imm[11],
                            req_imm[19:12], req_rd, req_opcode};
                enc_err  = ~fits21 | req_imm[0];
            end
            FMT_LI: begin
                if (fits12) begin
                    enc_word = {req_imm[11:0], REG_X0, F3_ADDI,
                                req_rd, OP_OP_IMM};
                end else begin
                    enc_word = {li_hi, req_rd, OP_LUI};
                    if (|req_imm[11:0]) begin
                        enc_two  = 1'b1;
                        enc_pend = {req_imm[11:0], req_rd, F3_ADDI,
                                    req_rd, OP_OP_IMM};
                    end
                end
            end
            default: begin
                enc_word = '0;
                enc_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_last  <= 1'b0;
            inst_err   <= 1'b0;
            pend       <= '0;
            accept_en  <= 1'b0;
        end else begin
            accept_en <= 1'b1;
            // req_ready can only be high in IDLE or in OUT_LAST with the word
            // being consumed, so an accept always means "load a new request".
            if (accept) begin
                inst_valid <= 1'b1;
                inst       <= enc_word;
                inst_last  <= ~enc_two;
                inst_err   <= enc_err;
                pend       <= enc_pend;
                state      <= enc_two ? OUT_FIRST : OUT_LAST;
            end else begin
                case (state)
                    OUT_FIRST: begin
                        if (inst_ready) begin
                            inst      <= pend;
                            inst_last <= 1'b1;
                            inst_err  <= 1'b0;
                            pend      <= '0;
                            state     <= OUT_LAST;
                        end
                    end
                    OUT_LAST: begin
                        if (inst_ready) begin
                            inst_valid <= 1'b0;
                            inst       <= '0;
                            inst_last  <= 1'b0;
                            inst_err   <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
